// File: rtl/load_use_ctrl_pkg.sv
// Shared types and defaults for the load-use suspend/flush controller.
// State encodings and the default data-RAM wait.
package load_use_ctrl_pkg;

  localparam int LOAD_LAT_DEF = 1;
  localparam int CNT_W_DEF    = 4;
  localparam int REG_W        = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FINISH = 2'd2
  } lu_state_e;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/load_use_ctrl_if.sv
// ID/EX hazard inputs and stall/flush outputs of the suspend controller.
// master = controller side, slave = pipeline side.
interface load_use_ctrl_if;
  import load_use_ctrl_pkg::*;

  reg_idx_t id_rR1;
  reg_idx_t id_rR2;
  logic     id_rR1_re;
  logic     id_rR2_re;
  reg_idx_t ex_wr;
  logic     ex_we;
  logic     ex_sel_ram;
  logic     ex_jump;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_flush;
  logic if_id_flush;
  logic id_ex_flush;
  logic suspend_finish;
  logic busy;

  modport master (
    input  id_rR1, id_rR2,
    input  id_rR1_re, id_rR2_re,
    input  ex_wr, ex_we,
    input  ex_sel_ram, ex_jump,
    output pc_stall, if_id_stall,
    output id_ex_stall, ex_mem_flush,
    output if_id_flush, id_ex_flush,
    output suspend_finish, busy
  );

  modport slave (
    output id_rR1, id_rR2,
    output id_rR1_re, id_rR2_re,
    output ex_wr, ex_we,
    output ex_sel_ram, ex_jump,
    input  pc_stall, if_id_stall,
    input  id_ex_stall, ex_mem_flush,
    input  if_id_flush, id_ex_flush,
    input  suspend_finish, busy
  );

endinterface

// File: rtl/lu_hazard_cmp.sv
// Combinational load-use comparator between the ID sources and EX load.
// x0 is never a hazard since it is hardwired to zero.
module lu_hazard_cmp
  import load_use_ctrl_pkg::*;
(
  input  reg_idx_t id_rR1,
  input  reg_idx_t id_rR2,
  input  logic     id_rR1_re,
  input  logic     id_rR2_re,
  input  reg_idx_t ex_wr,
  input  logic     ex_we,
  input  logic     ex_sel_ram,
  output logic     lu_hit
);

  logic ld_wr;
  logic m1;
  logic m2;

  assign ld_wr = ex_sel_ram & ex_we
               & (ex_wr != '0);
  assign m1 = id_rR1_re & (id_rR1 == ex_wr);
  assign m2 = id_rR2_re & (id_rR2 == ex_wr);
  assign lu_hit = ld_wr & (m1 | m2);

endmodule

// File: rtl/load_use_ctrl.sv
// Load-use suspend FSM plus branch/jump flush generation.
// Stalls/flushes are combinational; finish/busy decode state only.
module load_use_ctrl
  import load_use_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic            cpu_clk,
  input logic            cpu_rstn,
  load_use_ctrl_if.master bus
);

  lu_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             lu_hit;
  logic             stall;
  logic             flush;

  lu_hazard_cmp u_cmp (
    .id_rR1     (bus.id_rR1),
    .id_rR2     (bus.id_rR2),
    .id_rR1_re  (bus.id_rR1_re),
    .id_rR2_re  (bus.id_rR2_re),
    .ex_wr      (bus.ex_wr),
    .ex_we      (bus.ex_we),
    .ex_sel_ram (bus.ex_sel_ram),
    .lu_hit     (lu_hit)
  );

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.ex_jump && lu_hit) begin
            state <= WAIT;
            cnt   <= CNT_W'(LOAD_LAT);
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Gated by reset so a held hazard cannot leak out while in reset.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (cpu_rstn) begin
      unique case (state)
        IDLE: begin
          if (bus.ex_jump)
            flush = 1'b1;
          else if (lu_hit)
            stall = 1'b1;
        end
        WAIT:    stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_stall       = stall;
  assign bus.if_id_stall    = stall;
  assign bus.id_ex_stall    = stall;
  assign bus.ex_mem_flush   = stall;
  assign bus.if_id_flush    = flush;
  assign bus.id_ex_flush    = flush;
  assign bus.suspend_finish = (state == FINISH);
  assign bus.busy           = (state != IDLE);

endmodule
